// File: rtl/plru_ctrl.sv
// Tree-PLRU replacement controller for a 4-way cache over an external 3-bit-per-set array.
// Optional write-to-read forwarding enabled by defining PLRU_FWD_EN; otherwise same-set stalls.
module plru_ctrl #(
    parameter int unsigned S_INDEX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_op,
    input  logic [S_INDEX-1:0] req_set,
    input  logic [1:0]         req_way,
    output logic               rsp_valid,
    output logic [1:0]         rsp_way,
    input  logic               flush_req,
    output logic               flush_busy,
    output logic               flush_done,
    output logic               arr_csb0,
    output logic               arr_web0,
    output logic [S_INDEX-1:0] arr_addr0,
    output logic [2:0]         arr_din0,
    output logic               arr_csb1,
    output logic [S_INDEX-1:0] arr_addr1,
    input  logic [2:0]         arr_dout1
);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    state_e             state_q, state_d;
    logic               s1_valid_q;
    logic               s1_op_q;
    logic [S_INDEX-1:0] s1_set_q;
    logic [1:0]         s1_way_q;
    logic [S_INDEX-1:0] flush_cnt_q, flush_cnt_d;
    logic               flush_done_q, flush_done_d;

    logic               accept;
    logic               stall;
    logic [2:0]         s1_bits;
    logic [1:0]         s1_sel_way;
    logic [2:0]         s1_new_bits;

    // Each tree bit points toward the half holding the next victim.
    function automatic logic [1:0] victim_of(input logic [2:0] bits);
        victim_of = bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
    endfunction

    function automatic logic [2:0] touch_of(input logic [2:0] bits, input logic [1:0] way);
        logic [2:0] nb;
        nb    = bits;
        nb[0] = ~way[1];
        if (way[1]) begin
            nb[2] = ~way[0];
        end else begin
            nb[1] = ~way[0];
        end
        return nb;
    endfunction

`ifdef PLRU_FWD_EN
    logic               fwd_valid_q;
    logic [S_INDEX-1:0] fwd_set_q;
    logic [2:0]         fwd_bits_q;

    // The previous cycle's write is still in the array's input register, so a
    // same-set read returns stale data; take the bits from here instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid_q <= 1'b0;
            fwd_set_q   <= '0;
            fwd_bits_q  <= '0;
        end else begin
            fwd_valid_q <= s1_valid_q && (state_q == StRun);
            if (s1_valid_q) begin
                fwd_set_q  <= s1_set_q;
                fwd_bits_q <= s1_new_bits;
            end
        end
    end

    always_comb begin
        s1_bits = arr_dout1;
        if (fwd_valid_q && (fwd_set_q == s1_set_q)) begin
            s1_bits = fwd_bits_q;
        end
    end

    assign stall = 1'b0;
`else
    assign s1_bits = arr_dout1;
    // Hold off a same-set request for one cycle so its read sees the committed write.
    assign stall   = s1_valid_q && (s1_set_q == req_set);
`endif

    assign s1_sel_way  = s1_op_q ? victim_of(s1_bits) : s1_way_q;
    assign s1_new_bits = touch_of(s1_bits, s1_sel_way);

    assign req_ready = rst_n && (state_q == StRun) && !flush_req && !stall;
    assign accept    = req_valid && req_ready;

    assign arr_csb1  = !accept;
    assign arr_addr1 = req_set;
    assign arr_csb0  = 1'b0;

    assign rsp_valid  = s1_valid_q;
    assign rsp_way    = s1_valid_q ? s1_sel_way : 2'b00;
    assign flush_busy = (state_q == StFlush);
    assign flush_done = flush_done_q;

    always_comb begin
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;
        flush_done_d = 1'b0;
        arr_web0     = 1'b1;
        arr_addr0    = '0;
        arr_din0     = '0;

        unique case (state_q)
            StRun: begin
                // An in-flight stage-1 write lands this cycle, before the sweep starts.
                if (s1_valid_q) begin
                    arr_web0  = 1'b0;
                    arr_addr0 = s1_set_q;
                    arr_din0  = s1_new_bits;
                end
                if (flush_req) begin
                    state_d     = StFlush;
                    flush_cnt_d = '0;
                end
            end
            StFlush: begin
                arr_web0    = 1'b0;
                arr_addr0   = flush_cnt_q;
                arr_din0    = 3'b000;
                flush_cnt_d = flush_cnt_q + S_INDEX'(1);
                if (&flush_cnt_q) begin
                    state_d      = StRun;
                    flush_done_d = 1'b1;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            s1_valid_q   <= 1'b0;
            s1_op_q      <= 1'b0;
            s1_set_q     <= '0;
            s1_way_q     <= '0;
            flush_cnt_q  <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_valid_q   <= accept;
            flush_cnt_q  <= flush_cnt_d;
            flush_done_q <= flush_done_d;
            if (accept) begin
                s1_op_q  <= req_op;
                s1_set_q <= req_set;
                s1_way_q <= req_way;
            end
        end
    end

endmodule
